// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e       : sequencing states of the serial datapath controller
//   DEFAULT_WIDTH : operand width used when a block is not parameterised
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - bin.
// Ports:
//   a_i, b_i, bin_i : minuend bit, subtrahend bit, borrow in
//   diff_o          : difference bit
//   bout_o          : borrow out (set when a_i < b_i + bin_i)
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop replace the ripple chain.
// Ports:
//   clk_i, rst_i    : rising-edge clock, async active-high reset
//   start_i         : begin an operation (accepted in IDLE or DONE only)
//   a_i, b_i, bin_i : operands, sampled when start is accepted
//   busy_o          : high while bits are being processed
//   done_o          : one-cycle pulse when diff/bout/ovf are updated
//   diff_o          : a - b - bin modulo 2^WIDTH, held until the next done
//   bout_o          : unsigned borrow out
//   ovf_o           : two's-complement overflow
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | one operand bit pair processed per cycle, LSB first
// ST_DONE  | results just loaded; done pulse; may accept a new start
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o
);

  // One extra bit so the counter cannot wrap before reaching WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, bout_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_bit;
  logic             d_bit, borrow_nxt;

  full_subtractor u_fs (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (borrow_q),
    .diff_o (d_bit),
    .bout_o (borrow_nxt)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sh_q   <= a_i;
      b_sh_q   <= b_i;
      borrow_q <= bin_i;
      cnt_q    <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      borrow_q <= borrow_nxt;
      res_q    <= {d_bit, res_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + 1'b1;
      if (last_bit) begin
        // borrow_q here is the borrow into the MSB; its XOR with the
        // borrow out of the MSB is the signed overflow.
        diff_q <= {d_bit, res_q[WIDTH-1:1]};
        bout_q <= borrow_nxt;
        ovf_q  <= borrow_q ^ borrow_nxt;
      end
    end
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign done_o = (state_q == ST_DONE);
  assign diff_o = diff_q;
  assign bout_o = bout_q;
  assign ovf_o  = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic         bin_i;
  logic         busy_o, done_o, bout_o, ovf_o;
  logic [W-1:0] diff_o;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .diff_o  (diff_o),
    .bout_o  (bout_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic res_t ref_sub(input int a, input int b, input int bin);
    res_t r;
    int full, sa, sb, sd;
    full   = a - b - bin;
    r.diff = W'(full & ((1 << W) - 1));
    r.bout = (a < b + bin);
    sa     = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb     = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sd     = sa - sb - bin;
    r.ovf  = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    return r;
  endfunction

  // Issues one op; returns with the bench sitting on the negedge where done
  // is seen. lat = negedges after the accept edge (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, output res_t r, output int lat);
    @(negedge clk_i);
    start_i = 1'b1; a_i = a; b_i = b; bin_i = bin;
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done_o) begin
        lat = i;
        break;
      end
      @(negedge clk_i);
    end
    r.diff = diff_o; r.bout = bout_o; r.ovf = ovf_o;
  endtask

  initial begin
    vec_t vecs[7];
    res_t r, e;
    int   lat;
    int   first_done, second_done, held_bad, busy_bad, saw_done;

    vecs[0] = '{a:4'd9,  b:4'd3,  bin:1'b0, diff:4'd6,  bout:1'b0, ovf:1'b1};
    vecs[1] = '{a:4'd3,  b:4'd5,  bin:1'b0, diff:4'd14, bout:1'b1, ovf:1'b0};
    vecs[2] = '{a:4'd0,  b:4'd0,  bin:1'b1, diff:4'd15, bout:1'b1, ovf:1'b0};
    vecs[3] = '{a:4'd7,  b:4'd15, bin:1'b0, diff:4'd8,  bout:1'b1, ovf:1'b1};
    vecs[4] = '{a:4'd12, b:4'd4,  bin:1'b0, diff:4'd8,  bout:1'b0, ovf:1'b0};
    vecs[5] = '{a:4'd15, b:4'd15, bin:1'b1, diff:4'd15, bout:1'b1, ovf:1'b0};
    vecs[6] = '{a:4'd8,  b:4'd1,  bin:1'b0, diff:4'd7,  bout:1'b0, ovf:1'b1};

    rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
    #12;
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset diff", diff_o, 0);
    chk("reset bout", bout_o, 0);
    chk("reset ovf",  ovf_o,  0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table-driven directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, r, lat);
      chk($sformatf("vec%0d latency", i), lat, 5);
      chk($sformatf("vec%0d diff", i), r.diff, vecs[i].diff);
      chk($sformatf("vec%0d bout", i), r.bout, vecs[i].bout);
      chk($sformatf("vec%0d ovf", i),  r.ovf,  vecs[i].ovf);
      @(negedge clk_i);
      chk($sformatf("vec%0d done single", i), done_o, 0);
    end

    // Back-to-back with start held high
    @(negedge clk_i);
    start_i = 1'b1; a_i = 4'd7; b_i = 4'd15; bin_i = 1'b0;
    first_done = -1; second_done = -1; held_bad = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_i);
      if (first_done >= 0 && second_done < 0 && busy_o && diff_o !== 4'd8)
        held_bad++;
      if (done_o) begin
        if (first_done < 0) begin
          first_done = i;
          chk("b2b first diff", diff_o, 8);
          chk("b2b first bout", bout_o, 1);
          chk("b2b first ovf",  ovf_o,  1);
          a_i = 4'd9; b_i = 4'd3; bin_i = 1'b0;
        end else begin
          second_done = i;
          chk("b2b second diff", diff_o, 6);
          chk("b2b second bout", bout_o, 0);
          chk("b2b second ovf",  ovf_o,  1);
          start_i = 1'b0;
          break;
        end
      end
    end
    chk("b2b done spacing", second_done - first_done, 5);
    chk("b2b result held during op", held_bad, 0);

    // start during SHIFT is ignored
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; a_i = 4'd3; b_i = 4'd5; bin_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    busy_bad = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done_o) begin lat = i; break; end
      if (!busy_o) busy_bad++;
      if (i == 2) begin start_i = 1'b1; a_i = 4'd1; b_i = 4'd1; end
      else start_i = 1'b0;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    chk("ignore latency", lat, 5);
    chk("ignore busy held", busy_bad, 0);
    chk("ignore diff", diff_o, 14);
    chk("ignore bout", bout_o, 1);
    chk("ignore ovf",  ovf_o,  0);

    // Reset mid-operation
    @(negedge clk_i);
    start_i = 1'b1; a_i = 4'd9; b_i = 4'd3; bin_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("midrst busy", busy_o, 0);
    chk("midrst done", done_o, 0);
    chk("midrst diff", diff_o, 0);
    chk("midrst bout", bout_o, 0);
    chk("midrst ovf",  ovf_o,  0);
    @(negedge clk_i);
    rst_i = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (done_o) saw_done++;
    end
    chk("midrst no done", saw_done, 0);
    run_op(4'd12, 4'd4, 1'b0, r, lat);
    chk("postrst latency", lat, 5);
    chk("postrst diff", r.diff, 8);
    chk("postrst bout", r.bout, 0);
    chk("postrst ovf",  r.ovf,  0);

    // Exhaustive sweep against the reference model
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          run_op(W'(a), W'(b), 1'(c), r, lat);
          e = ref_sub(a, b, c);
          if (lat != 5 || r.diff !== e.diff || r.bout !== e.bout || r.ovf !== e.ovf) begin
            chk($sformatf("sweep a=%0d b=%0d bin=%0d lat", a, b, c), lat, 5);
            chk($sformatf("sweep a=%0d b=%0d bin=%0d diff", a, b, c), r.diff, e.diff);
            chk($sformatf("sweep a=%0d b=%0d bin=%0d bout", a, b, c), r.bout, e.bout);
            chk($sformatf("sweep a=%0d b=%0d bin=%0d ovf", a, b, c), r.ovf, e.ovf);
          end else begin
            n_cmp++;
          end
        end

    // Random ops with random idle gaps
    for (int k = 0; k < 150; k++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      rc = int'($urandom_range(1, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk_i);
      run_op(W'(ra), W'(rb), 1'(rc), r, lat);
      e = ref_sub(ra, rb, rc);
      chk($sformatf("rand%0d lat", k), lat, 5);
      chk($sformatf("rand%0d a=%0d b=%0d bin=%0d diff", k, ra, rb, rc), r.diff, e.diff);
      chk($sformatf("rand%0d bout", k), r.bout, e.bout);
      chk($sformatf("rand%0d ovf", k), r.ovf, e.ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_subtractor
